// File: rtl/riscv_mem_stage_v2.sv
// RISC-V MEM stage: issues loads/stores to a word-addressed cache and owns the MEM/WB register.
// Zero-wait accesses add no stall and sub-word stores without byte enables cost one extra read cycle; mem_stall holds upstream while d_stall is high.
module riscv_mem_stage_v2 #(
    parameter int BIT_W   = 32,
    parameter int ADDR_W  = BIT_W - $clog2(BIT_W / 8),
    parameter bit BYTE_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ex_valid,
    input  logic [BIT_W-1:0]     alu_result_in,
    input  logic [BIT_W-1:0]     store_data_in,
    input  logic [4:0]           rd_in,
    input  logic [2:0]           funct3_in,
    input  logic                 memrd_in,
    input  logic                 memwr_in,
    input  logic                 mem2reg_in,
    input  logic                 regwr_in,
    output logic                 mem_stall,
    output logic                 d_read,
    output logic                 d_write,
    output logic [ADDR_W-1:0]    d_addr,
    output logic [BIT_W-1:0]     d_wdata,
    output logic [BIT_W/8-1:0]   d_be,
    input  logic [BIT_W-1:0]     d_rdata,
    input  logic                 d_stall,
    output logic                 wb_valid,
    output logic                 wb_regwr,
    output logic                 wb_misalign,
    output logic [4:0]           wb_rd,
    output logic [BIT_W-1:0]     wb_data
);

    localparam int LANES = BIT_W / 8;
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [0:0] {S_IDLE, S_RMW_WR} state_t;

    state_t             state_q;
    logic [BIT_W-1:0]   merge_q;
    logic               wb_valid_q, wb_regwr_q, wb_misalign_q;
    logic [4:0]         wb_rd_q;
    logic [BIT_W-1:0]   wb_data_q;

    logic [OFF_W-1:0]   off;
    logic [1:0]         size;
    logic               mem_op, misalign, aligned_op, rmw;
    logic [LANES-1:0]   be_base, be_lane;
    logic [BIT_W-1:0]   wrep, merge_d, sh, keep, load_ext;
    logic               msb;

    assign off        = alu_result_in[OFF_W-1:0];
    assign size       = funct3_in[1:0];
    assign mem_op     = ex_valid & (memrd_in | memwr_in);
    assign aligned_op = mem_op & ~misalign;
    assign be_lane    = be_base << off;
    // Anything narrower than the full word needs a merge when the cache has no byte enables.
    assign rmw        = memwr_in & ~(&be_base) & ~BYTE_EN;
    assign d_addr     = ADDR_W'(alu_result_in >> OFF_W);

    always_comb begin
        misalign = 1'b0;
        be_base  = '1;
        wrep     = store_data_in;
        keep     = '1;
        msb      = 1'b0;
        sh       = d_rdata >> {off, 3'b000};
        case (size)
            2'd0: begin
                be_base = LANES'(1);
                wrep    = {LANES{store_data_in[7:0]}};
                keep    = BIT_W'(8'hFF);
                msb     = sh[7];
            end
            2'd1: begin
                misalign = alu_result_in[0];
                be_base  = LANES'(3);
                wrep     = {(LANES/2){store_data_in[15:0]}};
                keep     = BIT_W'(16'hFFFF);
                msb      = sh[15];
            end
            2'd2: begin
                misalign = |alu_result_in[1:0];
                be_base  = LANES'(4'hF);
                wrep     = {(LANES/4){store_data_in[31:0]}};
                keep     = BIT_W'(32'hFFFF_FFFF);
                msb      = sh[31];
            end
            default: begin
                misalign = |alu_result_in[2:0];
                msb      = sh[BIT_W-1];
            end
        endcase
        load_ext = (sh & keep) | (~keep & {BIT_W{~funct3_in[2] & msb}});
        for (int i = 0; i < LANES; i++) begin
            merge_d[8*i +: 8] = be_lane[i] ? wrep[8*i +: 8] : d_rdata[8*i +: 8];
        end
    end

    always_comb begin
        d_read    = 1'b0;
        d_write   = 1'b0;
        mem_stall = 1'b0;
        d_wdata   = wrep;
        d_be      = BYTE_EN ? be_lane : '1;
        if (state_q == S_RMW_WR) begin
            d_write   = 1'b1;
            d_wdata   = merge_q;
            d_be      = '1;
            mem_stall = d_stall;
        end else if (aligned_op) begin
            if (memwr_in && !rmw) d_write = 1'b1;
            else                  d_read  = 1'b1;
            mem_stall = d_stall | rmw;
        end
        if (!rst_n) begin
            d_read    = 1'b0;
            d_write   = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            merge_q       <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwr_q    <= 1'b0;
            wb_misalign_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (aligned_op && rmw && !d_stall) begin
                    merge_q <= merge_d;
                    state_q <= S_RMW_WR;
                end
                S_RMW_WR: if (!d_stall) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
            if (mem_stall) begin
                wb_valid_q    <= 1'b0;
                wb_regwr_q    <= 1'b0;
                wb_misalign_q <= 1'b0;
            end else begin
                wb_valid_q    <= ex_valid;
                wb_rd_q       <= rd_in;
                wb_regwr_q    <= ex_valid & regwr_in & ~misalign;
                wb_data_q     <= mem2reg_in ? load_ext : alu_result_in;
                wb_misalign_q <= mem_op & misalign;
            end
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_regwr    = wb_regwr_q;
    assign wb_misalign = wb_misalign_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_riscv_mem_stage_v2.sv
// Bench for riscv_mem_stage_v2: directed instructions, scoreboards for cache requests and MEM/WB results.
module tb_riscv_mem_stage_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] alu_result_in = '0, store_data_in = '0, d_rdata = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        memrd_in = 1'b0, memwr_in = 1'b0, mem2reg_in = 1'b0, regwr_in = 1'b0;
    logic        d_stall = 1'b0;

    logic        mem_stall, d_read, d_write, wb_valid, wb_regwr, wb_misalign;
    logic [29:0] d_addr;
    logic [31:0] d_wdata, wb_data;
    logic [3:0]  d_be;
    logic [4:0]  wb_rd;

    logic        b_mem_stall, b_d_read, b_d_write, b_wb_valid, b_wb_regwr, b_wb_misalign;
    logic [29:0] b_d_addr;
    logic [31:0] b_d_wdata, b_wb_data;
    logic [3:0]  b_d_be;
    logic [4:0]  b_wb_rd;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        regwr;
        logic        mis;
        bit          cmp_data;
    } wb_exp_t;

    typedef struct {
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    riscv_mem_stage_v2 #(.BIT_W(32), .BYTE_EN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in), .regwr_in(regwr_in),
        .mem_stall(mem_stall), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata), .d_stall(d_stall),
        .wb_valid(wb_valid), .wb_regwr(wb_regwr), .wb_misalign(wb_misalign),
        .wb_rd(wb_rd), .wb_data(wb_data)
    );

    riscv_mem_stage_v2 #(.BIT_W(32), .BYTE_EN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in), .regwr_in(regwr_in),
        .mem_stall(b_mem_stall), .d_read(b_d_read), .d_write(b_d_write), .d_addr(b_d_addr),
        .d_wdata(b_d_wdata), .d_be(b_d_be), .d_rdata(d_rdata), .d_stall(d_stall),
        .wb_valid(b_wb_valid), .wb_regwr(b_wb_regwr), .wb_misalign(b_wb_misalign),
        .wb_rd(b_wb_rd), .wb_data(b_wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void push_wb(input logic [4:0] rd, input logic [31:0] data,
                                    input logic regwr, input logic mis, input bit cmp_data);
        wb_exp_t e;
        e.rd = rd; e.data = data; e.regwr = regwr; e.mis = mis; e.cmp_data = cmp_data;
        wb_q.push_back(e);
    endfunction

    function automatic void push_req(input bit wr, input logic [29:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
        req_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be;
        req_q.push_back(e);
    endfunction

    // MEM/WB monitor: every valid retirement must match the oldest expected result.
    always begin : wb_mon
        wb_exp_t e;
        @(posedge clk); #2;
        if (wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h expected nothing", wb_rd, wb_data);
            end else begin
                e = wb_q.pop_front();
                chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                chk("wb_regwr", 64'(wb_regwr), 64'(e.regwr));
                chk("wb_misalign", 64'(wb_misalign), 64'(e.mis));
                if (e.cmp_data) chk("wb_data", 64'(wb_data), 64'(e.data));
            end
        end
    end

    // Cache monitor: every completing request must match the oldest expected request.
    always begin : req_mon
        req_exp_t e;
        @(negedge clk); #3;
        if ((d_read | d_write) === 1'b1 && d_stall === 1'b0) begin
            if (req_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL req_unexpected: got rd=%b wr=%b addr=%h expected nothing", d_read, d_write, d_addr);
            end else begin
                e = req_q.pop_front();
                chk("req_kind", {62'd0, d_read, d_write}, {62'd0, ~e.wr, e.wr});
                chk("req_addr", 64'(d_addr), 64'(e.addr));
                if (e.wr) begin
                    chk("req_wdata", 64'(d_wdata), 64'(e.wdata));
                    chk("req_be", 64'(d_be), 64'(e.be));
                end
            end
        end
    end

    task automatic run(input string name, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [2:0] f3, input bit rd_en, input bit wr_en, input logic [4:0] rd,
                       input logic [31:0] rdata, input int nstall, input int exp_stall,
                       input bit noreq, input bit stable_chk, input bit chk_b,
                       input logic [3:0] b_be, input logic [31:0] b_wd);
        int k, cnt;
        logic        w0;
        logic [29:0] a0;
        logic [31:0] d0;
        @(negedge clk);
        ex_valid = 1'b1; alu_result_in = addr; store_data_in = sd; funct3_in = f3;
        memrd_in = rd_en; memwr_in = wr_en; mem2reg_in = rd_en & ~wr_en; regwr_in = ~wr_en;
        rd_in = rd; d_rdata = rdata; k = 0; d_stall = (nstall > 0);
        #1;
        if (noreq) chk({name, "_noreq"}, 64'(d_read | d_write), 64'd0);
        if (chk_b) begin
            chk({name, "_b_write"}, 64'(b_d_write), 64'd1);
            chk({name, "_b_be"}, 64'(b_d_be), 64'(b_be));
            chk({name, "_b_wdata"}, 64'(b_d_wdata), 64'(b_wd));
            chk({name, "_b_stall"}, 64'(b_mem_stall), 64'd0);
        end
        w0 = d_write; a0 = d_addr; d0 = d_wdata; cnt = 0;
        while (mem_stall === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk); k++; d_stall = (k < nstall); #1;
            chk({name, "_bubble"}, 64'(wb_valid), 64'd0);
            if (stable_chk) chk({name, "_stable"}, {31'd0, d_write, 2'd0, d_addr, d0},
                                                   {31'd0, w0, 2'd0, a0, d_wdata});
        end
        chk({name, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
        @(posedge clk); #2;
        chk({name, "_retire"}, 64'(wb_valid), 64'd1);
    endtask

    initial begin
        ex_valid = 1'b1; memrd_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h104;
        #13;
        chk("rst_d_read", 64'(d_read), 64'd0);
        chk("rst_mem_stall", 64'(mem_stall), 64'd0);
        chk("rst_wb", {26'd0, wb_valid, wb_regwr, wb_misalign, wb_rd, wb_data}, 64'd0);
        @(negedge clk); ex_valid = 1'b0; memrd_in = 1'b0; rst_n = 1'b1;

        push_req(0, 30'h41, 0, 0); push_wb(5'd5, 32'hDEAD_BEEF, 1, 0, 1);
        run("lw", 32'h104, 0, 3'b010, 1, 0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
        push_req(0, 30'h40, 0, 0); push_wb(5'd6, 32'hFFFF_FF80, 1, 0, 1);
        run("lb", 32'h103, 0, 3'b000, 1, 0, 5'd6, 32'h8012_3456, 0, 0, 0, 0, 0, 0, 0);
        push_req(0, 30'h40, 0, 0); push_wb(5'd7, 32'h0000_0080, 1, 0, 1);
        run("lbu", 32'h103, 0, 3'b100, 1, 0, 5'd7, 32'h8012_3456, 0, 0, 0, 0, 0, 0, 0);
        push_req(0, 30'h40, 0, 0); push_wb(5'd8, 32'hFFFF_8001, 1, 0, 1);
        run("lh", 32'h102, 0, 3'b001, 1, 0, 5'd8, 32'h8001_1234, 0, 0, 0, 0, 0, 0, 0);
        push_req(0, 30'h40, 0, 0); push_wb(5'd9, 32'h0000_8001, 1, 0, 1);
        run("lhu", 32'h102, 0, 3'b101, 1, 0, 5'd9, 32'h8001_1234, 0, 0, 0, 0, 0, 0, 0);
        push_req(1, 30'h80, 32'hCAFE_F00D, 4'hF); push_wb(5'd10, 32'h200, 0, 0, 1);
        run("sw_stall", 32'h200, 32'hCAFE_F00D, 3'b010, 0, 1, 5'd10, 0, 3, 3, 0, 1, 0, 0, 0);
        push_req(0, 30'hC0, 0, 0); push_req(1, 30'hC0, 32'h1122_AB44, 4'hF);
        push_wb(5'd11, 32'h301, 0, 0, 1);
        run("sb_rmw", 32'h301, 32'h0000_00AB, 3'b000, 0, 1, 5'd11, 32'h1122_3344, 0, 1, 0, 0, 1,
            4'b0010, 32'hABAB_ABAB);
        push_req(0, 30'h100, 0, 0); push_req(1, 30'h100, 32'hBEEF_AAAA, 4'hF);
        push_wb(5'd12, 32'h402, 0, 0, 1);
        run("sh_rmw", 32'h402, 32'h0000_BEEF, 3'b001, 0, 1, 5'd12, 32'hAAAA_AAAA, 2, 3, 0, 0, 0, 0, 0);
        push_wb(5'd13, 0, 0, 1, 0);
        run("lw_mis", 32'h102, 0, 3'b010, 1, 0, 5'd13, 32'h5555_5555, 0, 0, 1, 0, 0, 0, 0);
        push_wb(5'd14, 32'h205, 0, 1, 1);
        run("sw_mis", 32'h205, 32'h1234_5678, 3'b010, 0, 1, 5'd14, 0, 0, 0, 1, 0, 0, 0, 0);
        push_wb(5'd15, 32'h1234_5678, 1, 0, 1);
        run("alu", 32'h1234_5678, 0, 3'b000, 0, 0, 5'd15, 0, 2, 0, 1, 0, 0, 0, 0);

        // Reset while the RMW write phase is held off by the cache.
        push_req(0, 30'hC0, 0, 0);
        @(negedge clk);
        ex_valid = 1'b1; alu_result_in = 32'h301; store_data_in = 32'hAB; funct3_in = 3'b000;
        memrd_in = 1'b0; memwr_in = 1'b1; mem2reg_in = 1'b0; regwr_in = 1'b0; rd_in = 5'd16;
        d_rdata = 32'h1122_3344; d_stall = 1'b0;
        #1 chk("rr_read", {62'd0, d_read, mem_stall}, 64'd3);
        @(negedge clk); d_stall = 1'b1;
        #1 chk("rr_wr_phase", {31'd0, d_write, mem_stall, d_wdata}, {31'd0, 2'b11, 32'h1122_AB44});
        rst_n = 1'b0;
        #1 chk("rr_drop", {62'd0, d_write, mem_stall}, 64'd0);
        @(negedge clk); ex_valid = 1'b0; memwr_in = 1'b0; d_stall = 1'b0; rst_n = 1'b1;
        #1 chk("rr_wb_zero", {26'd0, wb_valid, wb_regwr, wb_misalign, wb_rd, wb_data}, 64'd0);
        @(negedge clk); #1;
        chk("rr_idle", {62'd0, d_write, d_read}, 64'd0);

        repeat (3) @(negedge clk);
        chk("wb_q_empty", 64'(wb_q.size()), 64'd0);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
